// File: rtl/lp_ser_pkg.sv
// Shared widths and types for the low-power tree serializer.
package lp_ser_pkg;

  localparam int SER_WIDTH  = 16;
  localparam int SER_LEVELS = $clog2(SER_WIDTH);

  typedef logic [SER_WIDTH-1:0]  ser_word_t;
  typedef logic [SER_LEVELS-1:0] ser_cnt_t;

endpackage

// File: rtl/lp_ser_mux_stage.sv
// One registered 2:1 tree layer: N inputs fold to N/2 held outputs, reloaded only when enabled.
// data_o is the value the layer holds after the coming edge, so later layers see it without a cycle of skew.
module lp_ser_mux_stage #(
  parameter int N = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic           sel_i,
  input  logic [N-1:0]   data_i,
  output logic [N/2-1:0] data_o
);

  logic [N/2-1:0] data_q;
  logic [N/2-1:0] data_d;

  // sel_i picks the lower or upper half, so the widest layer decides the MSB of the bit index.
  always_comb begin
    // NOTE: default to the held value first so the enable-off path never infers a latch.
    data_d = data_q;
    if (en_i) begin
      data_d = sel_i ? data_i[N-1:N/2] : data_i[N/2-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_d;

endmodule

// File: rtl/lp_tree_serializer_core.sv
// 16:1 binary-tree serializer: one parallel capture per frame, LSB-first continuous serial stream.
// Wide layers reload rarely (every 8, 4, 2 cycles), only the final 1-bit layer toggles each clock.
module lp_tree_serializer_core
  import lp_ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] PAR_IN,
  output logic             SERIAL_OUT
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [LEVELS-1:0] cnt_q, cnt_d;
  logic [LEVELS-1:0] ph_q;
  logic [WIDTH-1:0]  leaf_q, leaf_d;
  logic              out_q, out_d;

  // Flat bus of every tree level: leaf at the bottom, each layer half as wide stacked above it.
  wire [2*WIDTH-2:0] tree;

  assign tree[WIDTH-1:0] = leaf_q;

  // ph_q trails cnt_q by one edge and is the index of the bit the output flop loads next.
  for (genvar s = 1; s <= LEVELS; s++) begin : g_stage
    localparam int N      = WIDTH >> (s - 1);
    localparam int IN_LO  = 2*WIDTH - 2*N;
    localparam int OUT_LO = 2*WIDTH - N;

    logic en;
    if (s == LEVELS) begin : g_always
      assign en = 1'b1;
    end else begin : g_gated
      assign en = (ph_q[LEVELS-s-1:0] == '0);
    end

    lp_ser_mux_stage #(.N(N)) u_stage (
      .clk_i  (CLK),
      .rst_ni (RESET),
      .en_i   (en),
      .sel_i  (ph_q[LEVELS-s]),
      .data_i (tree[IN_LO +: N]),
      .data_o (tree[OUT_LO +: N/2])
    );
  end

  always_comb begin
    cnt_d  = cnt_q + LEVELS'(1);
    leaf_d = (cnt_q == '0) ? PAR_IN : leaf_q;
    out_d  = tree[2*WIDTH-2];
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_q  <= '0;
      ph_q   <= '1;
      leaf_q <= '0;
      out_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ph_q   <= cnt_q;
      leaf_q <= leaf_d;
      out_q  <= out_d;
    end
  end

  assign SERIAL_OUT = out_q;

endmodule

// File: tb/tb_lp_tree_serializer_core.sv
// Bench for lp_tree_serializer_core: FIFO bit-stream reference model plus hand-computed word checks.
module tb_lp_tree_serializer_core;
  import lp_ser_pkg::*;

  logic      CLK = 1'b0;
  logic      RESET;
  ser_word_t PAR_IN;
  logic      SERIAL_OUT;

  always #5 CLK = ~CLK;

  lp_tree_serializer_core dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PAR_IN     (PAR_IN),
    .SERIAL_OUT (SERIAL_OUT)
  );

  int total = 0;
  int bad   = 0;

  int   edge_no = 0;
  logic out_log [0:4095];

  int        tb_cnt = 0;
  int        cap_edge [$];
  ser_word_t cap_word [$];

  logic bitq [$];
  int   m_cnt = 0;
  logic m_exp = 1'b0;
  bit   armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Log of the serial output after every rising edge, indexed by edge number.
  always @(posedge CLK) begin
    #1;
    if (edge_no < 4096) out_log[edge_no] = SERIAL_OUT;
    edge_no++;
  end

  // Reference model: each capture appends 16 bits LSB-first; each edge pops one bit (0 when empty).
  always @(posedge CLK) begin
    if (!RESET) begin
      bitq.delete();
      m_cnt = 0;
      m_exp = 1'b0;
      armed = 1'b1;
    end else begin
      m_exp = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      if (m_cnt == 0) begin
        for (int i = 0; i < SER_WIDTH; i++) bitq.push_back(PAR_IN[i]);
      end
      m_cnt = (m_cnt + 1) % SER_WIDTH;
    end
  end

  always @(negedge CLK) begin
    if (armed) check("stream", {31'd0, SERIAL_OUT}, {31'd0, m_exp});
  end

  task automatic step(input logic rst, input ser_word_t d);
    @(negedge CLK);
    RESET  = rst;
    PAR_IN = d;
    @(posedge CLK);
    #2;
    if (!rst) begin
      cap_edge.delete();
      cap_word.delete();
      tb_cnt = 0;
    end else begin
      if (tb_cnt == 0) begin
        cap_edge.push_back(edge_no - 1);
        cap_word.push_back(d);
      end
      tb_cnt = (tb_cnt + 1) % SER_WIDTH;
    end
  endtask

  // Pad with junk until the next capture edge, then present w on it; returns that edge index.
  task automatic send(input ser_word_t w, output int cap);
    while (tb_cnt != 0) step(1'b1, ser_word_t'($urandom));
    step(1'b1, w);
    cap = edge_no - 1;
  endtask

  // Drive X on the 15 non-capture edges, then present nxt on the following capture edge.
  task automatic finish_frame(input ser_word_t nxt);
    repeat (SER_WIDTH - 1) step(1'b1, 'x);
    step(1'b1, nxt);
  endtask

  function automatic ser_word_t word_at(input int cap);
    ser_word_t w;
    for (int i = 0; i < SER_WIDTH; i++) w[i] = out_log[cap + 1 + i];
    return w;
  endfunction

  task automatic check_caps(input string name);
    for (int k = 0; k < cap_edge.size(); k++) begin
      if (cap_edge[k] + SER_WIDTH < edge_no) begin
        check(name, {16'd0, word_at(cap_edge[k])}, {16'd0, cap_word[k]});
      end
    end
    cap_edge.delete();
    cap_word.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int        cap, cap2;
    ser_word_t exp_w;
    logic [31:0] exp32, got32;
    int        pos;
    logic      exp_seq [16] = '{1,1,1,1,0,1,0,1,1,0,1,0,0,0,1,1};
    int        run_len [5]  = '{8, 8, 4, 8, 4};
    logic      run_val [5]  = '{0, 1, 1, 0, 1};
    ser_word_t mid_vals [8] = '{16'h1357, 16'h2468, 16'hBEEF, 16'h0F0F,
                                16'h8001, 16'h7FFE, 16'h3C3C, 16'hDEAD};

    RESET  = 1'b0;
    PAR_IN = '0;

    // Reset hold
    step(1'b0, '0);
    step(1'b0, '0);
    check("reset_out", {31'd0, SERIAL_OUT}, 32'd0);

    // Idle after release with zero input
    repeat (17) begin
      step(1'b1, '0);
      check("idle_zero", {31'd0, SERIAL_OUT}, 32'd0);
    end
    cap_edge.delete();
    cap_word.delete();

    // Single word C5AF against the hand-listed bit sequence
    send(16'hC5AF, cap);
    finish_frame('0);
    for (int i = 0; i < SER_WIDTH; i++) exp_w[i] = exp_seq[i];
    check("c5af_seq", {16'd0, word_at(cap)}, {16'd0, exp_w});
    check_caps("c5af_word");

    // Back-to-back FF00 then F00F, judged as one 32-bit gapless stream
    send(16'hFF00, cap);
    finish_frame(16'hF00F);
    finish_frame('0);
    pos = 0;
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < run_len[r]; j++) begin
        exp32[pos] = run_val[r];
        pos++;
      end
    end
    for (int i = 0; i < 32; i++) got32[i] = out_log[cap + 1 + i];
    check("b2b_stream", got32, exp32);
    check_caps("b2b_word");

    // PAR_IN changes every 10 cycles; only capture-edge values may appear
    for (int n = 0; n < 80; n++) step(1'b1, mid_vals[n / 10]);
    repeat (17) step(1'b1, '0);
    check_caps("midframe_word");

    // Reset during bit 7 of CC33, then a clean restart
    send(16'hCC33, cap);
    repeat (7) step(1'b1, 'x);
    step(1'b0, 16'hCC33);
    check("abort_out", {31'd0, SERIAL_OUT}, 32'd0);
    step(1'b0, 16'hCC33);
    check("abort_hold", {31'd0, SERIAL_OUT}, 32'd0);
    send(16'h0F0F, cap2);
    check("restart_first_cap", cap2 - cap, 32'd10);
    check("restart_gap", {31'd0, out_log[cap2]}, 32'd0);
    finish_frame('0);
    check("restart_word", {16'd0, word_at(cap2)}, 32'h0000_0F0F);
    check_caps("restart_caps");

    // Sparse patterns, then a long run of zeros
    send(16'h8811, cap);
    finish_frame(16'hA815);
    finish_frame(16'hA995);
    finish_frame('0);
    check("sparse_8811", {16'd0, word_at(cap)}, 32'h0000_8811);
    check("sparse_a995", {16'd0, word_at(cap + 32)}, 32'h0000_A995);
    check_caps("sparse_word");
    repeat (60) begin
      step(1'b1, '0);
      check("tail_zero", {31'd0, SERIAL_OUT}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
